// File: rtl/envelope_follower_bank.sv
// Envelope follower bank: rectifies one frame of N band samples and applies attack/release
// one-pole smoothing over a single shared datapath, one band per clock.
module envelope_follower_bank #(
  parameter int unsigned N             = 15,
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned ATTACK_SHIFT  = 3,
  parameter int unsigned RELEASE_SHIFT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [N-1:0][WIDTH-1:0] band_in,
  input  logic                           band_valid,
  input  logic                           env_clear,
  output logic signed [N-1:0][WIDTH-1:0] envelope_out,
  output logic                           envelope_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   MaxMag  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   One     = (WIDTH+1)'(1);

  typedef enum logic [1:0] {StIdle, StProcess, StDone} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           index_q;
  logic [N-1:0][WIDTH-1:0]   band_reg_q;
  logic [N-1:0][WIDTH-1:0]   env_state_q;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] neg;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   env_e;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   step;
  logic             attack;
  logic [WIDTH-1:0] env_nxt;

  // Shared datapath: magnitudes are kept unsigned in WIDTH+1 bits so |MIN| cannot wrap.
  always_comb begin
    cur = band_reg_q[index_q];
    neg = '0 - cur;
    if (cur == MinVal) begin
      mag = MaxMag;
    end else if (cur[WIDTH-1]) begin
      mag = {1'b0, neg};
    end else begin
      mag = {1'b0, cur};
    end
    env_e  = {1'b0, env_state_q[index_q]};
    attack = (mag > env_e);
    diff   = attack ? (mag - env_e) : (env_e - mag);
    step   = attack ? (diff >> ATTACK_SHIFT) : (diff >> RELEASE_SHIFT);
    // Minimum step of one so the envelope lands exactly on the input.
    if ((diff != '0) && (step == '0)) begin
      step = One;
    end
    env_nxt = attack ? WIDTH'(env_e + step) : WIDTH'(env_e - step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      index_q        <= '0;
      band_reg_q     <= '0;
      env_state_q    <= '0;
      envelope_out   <= '0;
      envelope_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      envelope_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (env_clear) begin
            env_state_q <= '0;
            if (band_valid) begin
              overrun <= 1'b1;
            end
          end else if (band_valid) begin
            band_reg_q <= band_in;
            index_q    <= '0;
            state_q    <= StProcess;
          end
        end
        StProcess: begin
          if (band_valid || env_clear) begin
            overrun <= 1'b1;
          end
          env_state_q[index_q] <= env_nxt;
          if (index_q == LastIdx) begin
            state_q <= StDone;
          end else begin
            index_q <= index_q + IdxW'(1);
          end
        end
        StDone: begin
          if (band_valid || env_clear) begin
            overrun <= 1'b1;
          end
          envelope_out   <= env_state_q;
          envelope_valid <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_envelope_follower_bank.sv
// Scoreboard bench for envelope_follower_bank: expected envelopes are queued when a frame is
// driven and compared when envelope_valid pulses.
module tb_envelope_follower_bank;
  localparam int N     = 15;
  localparam int WIDTH = 16;
  localparam int ASH   = 3;
  localparam int RSH   = 8;
  localparam int LAT   = N + 1;

  typedef logic [N-1:0][WIDTH-1:0] frame_t;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic signed [N-1:0][WIDTH-1:0] band_in = '0;
  logic                           band_valid = 1'b0;
  logic                           env_clear = 1'b0;
  logic signed [N-1:0][WIDTH-1:0] envelope_out;
  logic                           envelope_valid;
  logic                           busy;
  logic                           overrun;

  int     total = 0;
  int     bad   = 0;
  frame_t exp_q[$];
  int     mdl[N];

  envelope_follower_bank #(
    .N(N), .WIDTH(WIDTH), .ATTACK_SHIFT(ASH), .RELEASE_SHIFT(RSH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .band_in(band_in), .band_valid(band_valid),
    .env_clear(env_clear), .envelope_out(envelope_out), .envelope_valid(envelope_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic frame_t fill(input int v);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = WIDTH'(v);
    return f;
  endfunction

  // Independent integer reference for one smoothing step.
  function automatic int mstep(input int e, input int x);
    int r;
    int s;
    r = (x < 0) ? -x : x;
    if (r > (1 << (WIDTH - 1)) - 1) r = (1 << (WIDTH - 1)) - 1;
    if (r == e) return e;
    s = (r > e) ? (r - e) / (1 << ASH) : (e - r) / (1 << RSH);
    if (s == 0) s = 1;
    return (r > e) ? e + s : e - s;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; band_valid = 1'b0; env_clear = 1'b0; band_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mdl[i] = 0;
    exp_q.delete();
  endtask

  // Drives one frame from a negedge and waits (bounded) for its valid pulse; band_valid is
  // re-pulsed after edge counts inj_a / inj_b, and tail extra cycles are watched for pulses.
  task automatic run_frame(input frame_t f, input int inj_a, input int inj_b, input int tail,
                           output int lat, output frame_t got, output int pulses);
    int edges;
    lat = -1; pulses = 0; got = '0;
    band_in = f; band_valid = 1'b1;
    @(negedge clk);
    band_valid = 1'b0;
    band_in    = fill(1234);
    edges      = 0;
    while (lat < 0 && edges < 40) begin
      band_valid = (edges == inj_a) || (edges == inj_b);
      @(negedge clk);
      edges++;
      if (envelope_valid) begin
        lat = edges; got = envelope_out; pulses++;
      end
    end
    band_valid = 1'b0;
    for (int k = 0; k < tail; k++) begin
      @(negedge clk);
      if (envelope_valid) pulses++;
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (envelope_out !== '0 || envelope_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out=%h valid=%b busy=%b ovr=%b, want all zero",
               envelope_out, envelope_valid, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_attack();
    int lat; int pulses; frame_t got; frame_t exp;
    int want[2] = '{1000, 1875};
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(fill(want[n]));
      run_frame(fill(8000), -1, -1, 3, lat, got, pulses);
      exp = exp_q.pop_front();
      total++;
      if (lat !== LAT || pulses !== 1) begin
        bad++;
        $display("FAIL attack_latency[%0d]: lat=%0d pulses=%0d, want lat=%0d pulses=1",
                 n, lat, pulses, LAT);
      end
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL attack[%0d] band %0d: got %0d want %0d", n, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_rectify();
    int lat; int pulses; frame_t got; frame_t exp; frame_t f;
    apply_reset();
    f = '0;
    f[0] = WIDTH'(-8000);
    f[1] = WIDTH'(-32768);
    exp = '0;
    exp[0] = WIDTH'(1000);
    exp[1] = WIDTH'(4095);
    exp_q.push_back(exp);
    run_frame(f, -1, -1, 0, lat, got, pulses);
    exp = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL rectify band %0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_release();
    int lat; int pulses; frame_t got; frame_t exp;
    int stim[4] = '{8000, 0, 40, 0};
    int want[4] = '{1000, 997, 5, 4};
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) apply_reset();
      exp_q.push_back(fill(want[n]));
      run_frame(fill(stim[n]), -1, -1, 0, lat, got, pulses);
      exp = exp_q.pop_front();
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL release[%0d] band %0d: got %0d want %0d", n, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int lat; int pulses; frame_t got; frame_t exp;
    apply_reset();
    exp_q.push_back(fill(1000));
    run_frame(fill(8000), 5, LAT - 1, 5, lat, got, pulses);
    exp = exp_q.pop_front();
    total++;
    if (overrun !== 1'b1 || pulses !== 1 || lat !== LAT) begin
      bad++;
      $display("FAIL overrun_ignore: ovr=%b pulses=%0d lat=%0d, want ovr=1 pulses=1 lat=%0d",
               overrun, pulses, lat, LAT);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL overrun band %0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; int pulses; frame_t got; frame_t exp;
    apply_reset();
    exp_q.push_back(fill(1000));
    run_frame(fill(8000), -1, -1, 0, lat, got, pulses);
    void'(exp_q.pop_front());
    // Second frame is cut off at index 7 after an injected overrun.
    band_in = fill(8000); band_valid = 1'b1;
    @(negedge clk);
    band_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      band_valid = (k == 3);
      @(negedge clk);
    end
    band_valid = 1'b0;
    total++;
    if (overrun !== 1'b1 || busy !== 1'b1 || envelope_out !== fill(1000)) begin
      bad++;
      $display("FAIL pre_reset: ovr=%b busy=%b out0=%0d, want ovr=1 busy=1 out0=1000",
               overrun, busy, envelope_out[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (envelope_out !== '0 || envelope_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out=%h valid=%b busy=%b ovr=%b, want all zero",
               envelope_out, envelope_valid, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mdl[i] = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (envelope_valid || busy) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_no_pulse: active cycles=%0d, want 0", pulses);
    end
    exp_q.push_back(fill(1000));
    run_frame(fill(8000), -1, -1, 0, lat, got, pulses);
    exp = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL after_reset band %0d: got %0d want %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_clear();
    int lat; int pulses; frame_t got; frame_t exp;
    int held;
    apply_reset();
    exp_q.push_back(fill(1000));
    run_frame(fill(8000), -1, -1, 0, lat, got, pulses);
    void'(exp_q.pop_front());
    env_clear = 1'b1;
    @(negedge clk);
    env_clear = 1'b0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (envelope_out === fill(1000) && !busy) held++;
    end
    total++;
    if (held !== 4) begin
      bad++;
      $display("FAIL clear_holds_out: good cycles=%0d, want 4", held);
    end
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(fill(1000));
      run_frame(fill(8000), -1, -1, 0, lat, got, pulses);
      exp = exp_q.pop_front();
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL clear[%0d] band %0d: got %0d want %0d", n, i, got[i], exp[i]);
        end
      end
      if (n == 0) begin
        total++;
        if (overrun !== 1'b0) begin
          bad++;
          $display("FAIL clear_no_overrun: ovr=%b want 0", overrun);
        end
        // Clear together with a frame: frame is dropped, state zeroed, overrun set.
        env_clear = 1'b1; band_valid = 1'b1; band_in = fill(8000);
        @(negedge clk);
        env_clear = 1'b0; band_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (envelope_valid || busy) pulses++;
        end
        total++;
        if (pulses !== 0 || overrun !== 1'b1 || envelope_out !== fill(1000)) begin
          bad++;
          $display("FAIL clear_and_frame: active=%0d ovr=%b out0=%0d, want 0 1 1000",
                   pulses, overrun, envelope_out[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; int pulses; frame_t got; frame_t exp; frame_t f;
    int late;
    apply_reset();
    late = 0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) begin
        if (i % 3 == 0) f[i] = WIDTH'($urandom_range(0, 200));
        else            f[i] = WIDTH'($urandom);
      end
      if (n == 2) f[4] = WIDTH'(-32768);
      for (int i = 0; i < N; i++) begin
        mdl[i] = mstep(mdl[i], int'($signed(f[i])));
        exp[i] = WIDTH'(mdl[i]);
      end
      exp_q.push_back(exp);
      run_frame(f, -1, -1, 0, lat, got, pulses);
      exp = exp_q.pop_front();
      if (lat !== LAT) late++;
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== exp[i]) begin
          bad++;
          $display("FAIL b2b[%0d] band %0d: got %0d want %0d", n, i, got[i], exp[i]);
        end
      end
    end
    total++;
    if (late !== 0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_throughput: late frames=%0d ovr=%b, want 0 0", late, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_rectify();
    test_release();
    test_overrun();
    test_reset_mid();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
